// File: rtl/steer_en.sv
// Rider-detect / steering-enable FSM driven by the two load-cell readings.
// Applies weight hysteresis and a left/right balance check before and after the settle timer.
module steer_en #(
  parameter bit          fast_sim      = 1'b0,
  parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
  parameter logic [11:0] WT_HYSTERESIS = 12'h040
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  output logic        en_steer,
  output logic        rider_off
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
  } state_t;

  localparam logic [12:0] RIDER_ON_THR  = {1'b0, MIN_RIDER_WT};
  localparam logic [12:0] RIDER_OFF_THR = {1'b0, MIN_RIDER_WT - WT_HYSTERESIS};

  state_t      state_q, state_d;
  logic [25:0] tmr_q, tmr_d;
  logic        clr_tmr;

  logic [12:0] sum;
  logic [12:0] diff;
  logic [12:0] neg_diff;
  logic [12:0] abs_diff;
  logic        sum_gt_min;
  logic        sum_lt_min;
  logic        diff_gt_1_4;
  logic        diff_gt_15_16;
  logic        tmr_full;

  always_comb begin
    sum           = {1'b0, lft_ld} + {1'b0, rght_ld};
    diff          = {1'b0, lft_ld} - {1'b0, rght_ld};
    neg_diff      = 13'd0 - diff;
    abs_diff      = diff[12] ? neg_diff : diff;
    sum_gt_min    = (sum > RIDER_ON_THR);
    sum_lt_min    = (sum < RIDER_OFF_THR);
    // With sum = 0 the magnitude is also 0, so neither strict compare can fire.
    diff_gt_1_4   = (abs_diff > (sum >> 2));
    diff_gt_15_16 = (abs_diff > (sum - (sum >> 4)));
    tmr_full      = fast_sim ? (&tmr_q[14:0]) : (&tmr_q[25:0]);
  end

  always_comb begin
    state_d = state_q;
    clr_tmr = 1'b0;
    case (state_q)
      IDLE: begin
        if (sum_gt_min) begin
          state_d = WAIT;
          clr_tmr = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (sum_lt_min) begin
          state_d = IDLE;
        end else if (diff_gt_1_4) begin
          state_d = WAIT;
          clr_tmr = 1'b1;
        end else if (tmr_full) begin
          state_d = STEER;
        end else begin
          state_d = WAIT;
        end
      end
      STEER: begin
        if (sum_lt_min) begin
          state_d = IDLE;
        end else if (diff_gt_15_16) begin
          state_d = WAIT;
          clr_tmr = 1'b1;
        end else begin
          state_d = STEER;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Settle timer free-runs and wraps; only its value while in WAIT matters.
  always_comb begin
    if (clr_tmr) begin
      tmr_d = 26'd0;
    end else begin
      tmr_d = tmr_q + 26'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= 26'd0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  assign en_steer  = (state_q == STEER);
  assign rider_off = (state_q == IDLE);

endmodule

// File: tb/tb_steer_en.sv
// Directed bench for steer_en with fast_sim=1: thresholds, balance checks,
// settle latency and synchronous reset behaviour.
module tb_steer_en;

  logic        clk;
  logic        rst_n;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        en_steer;
  logic        rider_off;

  int checks;
  int errors;
  int n_edges;

  localparam int SETTLE = 32768;
  localparam int BOUND  = 40000;

  steer_en #(
    .fast_sim      (1'b1),
    .MIN_RIDER_WT  (12'h200),
    .WT_HYSTERESIS (12'h040)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .en_steer  (en_steer),
    .rider_off (rider_off)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic count_settle(output int n);
    n = 0;
    while (!en_steer && n < BOUND) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    lft_ld  = 12'h000;
    rght_ld = 12'h000;

    step(5);
    check_val("rst_en_steer", en_steer, 0);
    check_val("rst_rider_off", rider_off, 1);

    rst_n = 1'b1;
    step(100);
    check_val("empty_idle", rider_off, 1);

    // Top of hysteresis band is not a mount; one count above is.
    lft_ld = 12'h100; rght_ld = 12'h100;
    step(10);
    check_val("sum200_idle", rider_off, 1);
    lft_ld = 12'h101;
    step(1);
    check_val("sum201_wait_off", rider_off, 0);
    check_val("sum201_wait_en", en_steer, 0);

    // Imbalance in WAIT keeps clearing the timer.
    lft_ld = 12'h200; rght_ld = 12'h0A0;
    step(1000);
    check_val("wait_imbal_en", en_steer, 0);
    check_val("wait_imbal_off", rider_off, 0);
    lft_ld = 12'h150; rght_ld = 12'h150;
    count_settle(n_edges);
    check_val("rebal_settle_edges", n_edges, SETTLE);
    check_val("steer_en", en_steer, 1);

    // 1/4 imbalance tolerated in STEER; hysteresis band holds STEER.
    lft_ld = 12'h200; rght_ld = 12'h0A0;
    step(5);
    check_val("steer_quarter_hold", en_steer, 1);
    lft_ld = 12'h0E8; rght_ld = 12'h0E8;
    step(5);
    check_val("steer_band_en", en_steer, 1);
    check_val("steer_band_off", rider_off, 0);

    lft_ld = 12'h290; rght_ld = 12'h010;
    step(1);
    check_val("steer_1516_en", en_steer, 0);
    check_val("steer_1516_wait", rider_off, 0);
    step(50);
    check_val("wait_hold_en", en_steer, 0);

    // A low pulse that does not span a rising edge does nothing.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step(1);
    check_val("async_pulse_ignored", rider_off, 0);

    #2 rst_n = 1'b0;
    #2;
    check_val("rst_pre_edge", rider_off, 0);
    step(1);
    check_val("rst_edge_off", rider_off, 1);
    check_val("rst_edge_en", en_steer, 0);
    lft_ld = 12'h150; rght_ld = 12'h150;
    step(3);
    check_val("rst_held_idle", rider_off, 1);

    rst_n = 1'b1;
    step(1);
    check_val("rel_wait_entry", rider_off, 0);
    count_settle(n_edges);
    check_val("rel_settle_edges", n_edges, SETTLE);
    check_val("rel_steer_en", en_steer, 1);

    // Below the dismount threshold drops straight to IDLE.
    lft_ld = 12'h0D8; rght_ld = 12'h0D8;
    step(1);
    check_val("dismount_off", rider_off, 1);
    check_val("dismount_en", en_steer, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
